lane_toggle_monitor: RTL and testbench
======================================

# lane_toggle_monitor

Measurement stage that consumes a vector of per-lane status bits, such as the count outputs of a generated per-lane counter bank, and characterises their activity over a fixed window of `clk` cycles. Per lane it counts toggles with saturating counters and sets a sticky overflow flag. In parallel it folds the raw lane values into a 64-bit MISR signature. A start/done handshake lets a self-checking top launch a window and compare `sig` and `toggles` against expected constants.

## Interface
- `LANES`, 2: number of monitored lanes (1..32).
- `CNT_W`, 8: width of each per-lane toggle counter (2..16).
- `WINDOW`, 80: RUN-state length in cycles (1..65535).
- `SYNC_STAGES`, 2: synchronizer depth on `lane_in` (2..4).
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `lane_in`  in  LANES  monitored bits; may be from another clock domain.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  single-cycle pulse at the end of a window.
- `sig`  out  64  MISR signature.
- `toggles`  out  LANES*CNT_W  per-lane toggle counts; lane i occupies bits [i*CNT_W +: CNT_W].
- `overflow`  out  LANES  per-lane sticky saturation flag.

## Operation
- Reset values are all 0: `busy`, `done`, `sig`, `toggles`, `overflow`, synchronizer flops, previous-value register, window counter. State is IDLE.
- `lane_in` passes through a SYNC_STAGES-deep flop chain to produce `lane_s`.
- `lane_prev` <= `lane_s` every cycle in every state.
- FSM states are IDLE, WARMUP, RUN and DONE.
  - IDLE: `start`=1 moves to WARMUP and clears `sig`, `toggles`, `overflow` and the window counter.
  - WARMUP: lasts SYNC_STAGES cycles to flush the synchronizer, then moves to RUN.
  - RUN: lasts WINDOW cycles, then moves to DONE.
  - DONE: lasts 1 cycle with `done`=1, then moves to IDLE unconditionally.
- In RUN only, each cycle:
  - toggle[i] = `lane_s[i]` ^ `lane_prev[i]`.
  - If toggle[i]=1 and the count is below all-ones, count[i] increments. If toggle[i]=1 and the count is already all-ones, the count holds and `overflow[i]` is set.
  - sig <= {sig[62:0], sig[63]^sig[2]^sig[0]} ^ {(64-LANES)'b0, lane_s}.
- `start` is ignored outside IDLE; no queuing.
- Results hold after DONE until the next accepted start.
- `rst` asserted mid-window: next cycle is IDLE with all outputs 0; no `done` pulse.
- `rst` and `start` in the same cycle: `rst` wins.

## Timing
- `start` accepted at edge t: `busy`=1 from t+1.
- RUN occupies edges t+1+SYNC_STAGES through t+SYNC_STAGES+WINDOW.
- `done`=1 during cycle t+1+SYNC_STAGES+WINDOW.
- `busy`=0 from t+2+SYNC_STAGES+WINDOW.
- Earliest next accepted start: the cycle `busy` returns to 0.
- Outputs are registered, with no combinational path from inputs. `sig`/`toggles` are final and stable when `done`=1.
- Lane input-to-detection latency is SYNC_STAGES+1 cycles.

## Structure
- Package `lane_mon_pkg`:
  - state enum `lm_state_e` (IDLE, WARMUP, RUN, DONE);
  - constant `MISR_W`=64;
  - constant `MISR_TAPS` (bits 63, 2, 0);
  - function `misr_step(sig, din)`.
- Sub-module `lane_sync_edge`: one lane's synchronizer chain, previous-value flop and toggle output. Instantiated LANES times via generate.
- Counters, overflow flags, MISR and FSM live in the top module.

## Test plan
- Idle lanes: LANES=2, WINDOW=16, `lane_in`=2'b00 constant, `start` pulse → `toggles`=0, `overflow`=0, `sig`=64'h0, `done` exactly 19 cycles after start.
- Active lane: lane0 inverts every cycle, lane1 constant 0, WINDOW=16, CNT_W=8 → toggles[7:0]=16, toggles[15:8]=0, `overflow`=2'b00.
- Saturation: CNT_W=4, WINDOW=20, lane0 inverts every cycle → toggles[3:0]=4'hF, `overflow[0]`=1, `overflow[1]`=0.
- Signature: LANES=2, WINDOW=3, `lane_in`=2'b01 constant → `sig`=64'h5 at `done`.
- Handshake: `start` re-pulsed during WARMUP and during RUN → ignored; single `done` at the original cycle; `busy` drops the next cycle; then a start in IDLE is accepted.
- Reset mid-RUN: assert `rst` 1 cycle at RUN cycle 5 → all outputs 0 the next cycle, no `done` pulse; a subsequent start completes normally.

Source files
------------

// File: rtl/lane_mon_pkg.sv
// Shared types and MISR helper for the lane toggle monitor.
package lane_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } lm_state_e;

  localparam int MISR_W = 64;
  localparam logic [MISR_W-1:0] MISR_TAPS = 64'h8000_0000_0000_0005;

  // One MISR step: shift left, feed back the tap parity, then fold in the data word.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                  input logic [MISR_W-1:0] din);
    return {sig[MISR_W-2:0], ^(sig & MISR_TAPS)} ^ din;
  endfunction

endpackage

// File: rtl/lane_sync_edge.sv
// One lane: synchronizer chain, previous-value flop and toggle detect.
module lane_sync_edge
  import lane_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lane_i,
  output logic lane_s_o,
  output logic toggle_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lane_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lane_s_o = sync_q[SYNC_STAGES-1];
  assign toggle_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/lane_toggle_monitor.sv
// Windowed per-lane toggle counter with sticky saturation flags and a MISR signature.
//   state  | meaning
//   IDLE   | results held, waiting for start
//   WARMUP | SYNC_STAGES cycles flushing the synchronizers
//   RUN    | WINDOW cycles counting toggles and folding the MISR
//   DONE   | one-cycle done pulse, results final
module lane_toggle_monitor
  import lane_mon_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [LANES-1:0]       lane_in_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [MISR_W-1:0]      sig_o,
  output logic [LANES*CNT_W-1:0] toggles_o,
  output logic [LANES-1:0]       overflow_o
);

  localparam int WIN_W = 16;

  lm_state_e                   state_q, state_d;
  logic [WIN_W-1:0]            win_q, win_d;
  logic [LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0]            ovf_q, ovf_d;
  logic [MISR_W-1:0]           sig_q, sig_d;
  logic                        busy_q, done_q;
  logic [LANES-1:0]            lane_s;
  logic [LANES-1:0]            toggle;
  logic                        accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .lane_i   (lane_in_i[g]),
      .lane_s_o (lane_s[g]),
      .toggle_o (toggle[g])
    );
  end

  assign accept = (state_q == IDLE) && start_i;

  // One down-counter serves both WARMUP and RUN; terminal count at zero.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WARMUP;
          win_d   = WIN_W'(SYNC_STAGES - 1);
        end
      end
      WARMUP: begin
        if (win_q == '0) begin
          state_d = RUN;
          win_d   = WIN_W'(WINDOW - 1);
        end else begin
          win_d = win_q - 16'd1;
        end
      end
      RUN: begin
        if (win_q == '0) begin
          state_d = DONE;
        end else begin
          win_d = win_q - 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    sig_d = sig_q;
    if (accept) begin
      cnt_d = '0;
      ovf_d = '0;
      sig_d = '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < LANES; i++) begin
        if (toggle[i]) begin
          if (&cnt_q[i]) begin
            ovf_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
      sig_d = misr_step(sig_q, MISR_W'(lane_s));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sig_q   <= sig_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sig_o      = sig_q;
  assign toggles_o  = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_lane_toggle_monitor.sv
// Self-checking bench: three monitor configurations driven from a vector table with a result scoreboard.
module tb_lane_toggle_monitor;

  typedef struct {
    int          dut;
    logic [1:0]  base;
    logic [1:0]  tmask;
    logic [15:0] tog;
    logic [1:0]  ovf;
    logic        chk_sig;
    logic [63:0] sig;
  } vec_t;

  logic clk;
  logic ph;
  int   n_cmp = 0;
  int   n_err = 0;

  // A: W16 C8, B: W3 C8, C: W20 C4
  logic        a_rst, a_start, a_busy, a_done;
  logic [1:0]  a_lane, a_base, a_tmask, a_ovf;
  logic [63:0] a_sig;
  logic [15:0] a_tog;
  logic        b_rst, b_start, b_busy, b_done;
  logic [1:0]  b_lane, b_base, b_tmask, b_ovf;
  logic [63:0] b_sig;
  logic [15:0] b_tog;
  logic        c_rst, c_start, c_busy, c_done;
  logic [1:0]  c_lane, c_base, c_tmask, c_ovf;
  logic [63:0] c_sig;
  logic [7:0]  c_tog;

  assign a_lane = a_base ^ (a_tmask & {2{ph}});
  assign b_lane = b_base ^ (b_tmask & {2{ph}});
  assign c_lane = c_base ^ (c_tmask & {2{ph}});

  lane_toggle_monitor #(.LANES(2), .CNT_W(8), .WINDOW(16), .SYNC_STAGES(2)) u_a (
    .clk_i(clk), .rst_i(a_rst), .start_i(a_start), .lane_in_i(a_lane),
    .busy_o(a_busy), .done_o(a_done), .sig_o(a_sig), .toggles_o(a_tog), .overflow_o(a_ovf));
  lane_toggle_monitor #(.LANES(2), .CNT_W(8), .WINDOW(3), .SYNC_STAGES(2)) u_b (
    .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .lane_in_i(b_lane),
    .busy_o(b_busy), .done_o(b_done), .sig_o(b_sig), .toggles_o(b_tog), .overflow_o(b_ovf));
  lane_toggle_monitor #(.LANES(2), .CNT_W(4), .WINDOW(20), .SYNC_STAGES(2)) u_c (
    .clk_i(clk), .rst_i(c_rst), .start_i(c_start), .lane_in_i(c_lane),
    .busy_o(c_busy), .done_o(c_done), .sig_o(c_sig), .toggles_o(c_tog), .overflow_o(c_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Toggling lanes flip on every falling edge.
  initial begin
    ph = 1'b0;
    forever begin
      @(negedge clk);
      ph = ~ph;
    end
  end

  function automatic logic [63:0] misr_ref(input logic [1:0] din, input int steps);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < steps; k++) begin
      s = {s[62:0], s[63] ^ s[2] ^ s[0]} ^ {62'b0, din};
    end
    return s;
  endfunction

  function automatic logic g_done(input int d);
    case (d)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  function automatic logic g_busy(input int d);
    case (d)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic logic [63:0] g_sig(input int d);
    case (d)
      0:       return a_sig;
      1:       return b_sig;
      default: return c_sig;
    endcase
  endfunction

  function automatic logic [15:0] g_tog(input int d);
    case (d)
      0:       return a_tog;
      1:       return b_tog;
      default: return {8'h00, c_tog};
    endcase
  endfunction

  function automatic logic [1:0] g_ovf(input int d);
    case (d)
      0:       return a_ovf;
      1:       return b_ovf;
      default: return c_ovf;
    endcase
  endfunction

  task automatic set_start(input int d, input logic v);
    case (d)
      0:       a_start = v;
      1:       b_start = v;
      default: c_start = v;
    endcase
  endtask

  task automatic set_lanes(input int d, input logic [1:0] base, input logic [1:0] tmask);
    case (d)
      0:       begin a_base = base; a_tmask = tmask; end
      1:       begin b_base = base; b_tmask = tmask; end
      default: begin c_base = base; c_tmask = tmask; end
    endcase
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  vec_t sb[$];

  // Launch one window, wait (bounded) for done, then score against the queued expectation.
  task automatic run_vec(input int d, input int lat, input string nm);
    int   n;
    bit   seen;
    vec_t e;
    @(negedge clk);
    set_start(d, 1'b1);
    n    = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      set_start(d, 1'b0);
      if (g_done(d)) seen = 1;
    end
    chk({nm, "/latency"}, 64'(n), 64'(lat));
    if (sb.size() == 0) begin
      chk({nm, "/scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "/toggles"}, 64'(g_tog(d)), 64'(e.tog));
      chk({nm, "/overflow"}, 64'(g_ovf(d)), 64'(e.ovf));
      if (e.chk_sig) chk({nm, "/sig"}, g_sig(d), e.sig);
      @(posedge clk);
      #1;
      chk({nm, "/busy_after"}, 64'(g_busy(d)), 64'd0);
      chk({nm, "/done_after"}, 64'(g_done(d)), 64'd0);
      chk({nm, "/toggles_hold"}, 64'(g_tog(d)), 64'(e.tog));
    end
  endtask

  vec_t vecs[12];
  int   lat_of[3];

  initial begin
    int dcount;
    int first;
    logic busy_after;

    lat_of[0] = 19;
    lat_of[1] = 6;
    lat_of[2] = 23;

    vecs[0]  = '{0, 2'b00, 2'b00, 16'h0000, 2'b00, 1'b1, 64'h0};
    vecs[1]  = '{0, 2'b00, 2'b01, 16'h0010, 2'b00, 1'b0, 64'h0};
    vecs[2]  = '{0, 2'b00, 2'b10, 16'h1000, 2'b00, 1'b0, 64'h0};
    vecs[3]  = '{0, 2'b00, 2'b11, 16'h1010, 2'b00, 1'b0, 64'h0};
    vecs[4]  = '{0, 2'b11, 2'b00, 16'h0000, 2'b00, 1'b1, misr_ref(2'b11, 16)};
    vecs[5]  = '{0, 2'b10, 2'b00, 16'h0000, 2'b00, 1'b1, misr_ref(2'b10, 16)};
    vecs[6]  = '{1, 2'b01, 2'b00, 16'h0000, 2'b00, 1'b1, 64'h5};
    vecs[7]  = '{1, 2'b11, 2'b00, 16'h0000, 2'b00, 1'b1, 64'hA};
    vecs[8]  = '{2, 2'b00, 2'b01, 16'h000F, 2'b01, 1'b0, 64'h0};
    vecs[9]  = '{2, 2'b00, 2'b11, 16'h00FF, 2'b11, 1'b0, 64'h0};
    vecs[10] = '{2, 2'b00, 2'b00, 16'h0000, 2'b00, 1'b1, 64'h0};
    vecs[11] = '{1, 2'b00, 2'b01, 16'h0003, 2'b00, 1'b0, 64'h0};

    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_base = '0; a_tmask = '0; b_base = '0; b_tmask = '0; c_base = '0; c_tmask = '0;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    chk("reset/busy", 64'(a_busy), 64'd0);
    chk("reset/done", 64'(a_done), 64'd0);
    chk("reset/sig", a_sig, 64'd0);
    chk("reset/toggles", 64'(a_tog), 64'd0);
    chk("reset/overflow", 64'(c_ovf), 64'd0);

    foreach (vecs[v]) begin
      set_lanes(vecs[v].dut, vecs[v].base, vecs[v].tmask);
      repeat (6) @(posedge clk);
      sb.push_back(vecs[v]);
      run_vec(vecs[v].dut, lat_of[vecs[v].dut], $sformatf("vec%0d", v));
    end

    // Start re-pulsed in WARMUP and in RUN must be ignored.
    set_lanes(0, 2'b00, 2'b01);
    repeat (6) @(posedge clk);
    @(negedge clk);
    a_start    = 1'b1;
    dcount     = 0;
    first      = 0;
    busy_after = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      a_start = (k == 1) || (k == 7);
      if (first != 0 && k == first + 1) busy_after = a_busy;
      if (a_done) begin
        dcount++;
        if (first == 0) first = k;
      end
    end
    chk("hs/done_count", 64'(dcount), 64'd1);
    chk("hs/done_cycle", 64'(first), 64'd19);
    chk("hs/busy_drop", 64'(busy_after), 64'd0);
    sb.push_back('{0, 2'b00, 2'b01, 16'h0010, 2'b00, 1'b0, 64'h0});
    run_vec(0, 19, "hs_restart");

    // Reset during the fifth RUN cycle aborts the window without a done pulse.
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst/pre_toggles_nonzero", 64'(a_tog != 16'h0), 64'd1);
    @(negedge clk);
    a_rst = 1'b1;
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    chk("rst/busy", 64'(a_busy), 64'd0);
    chk("rst/done", 64'(a_done), 64'd0);
    chk("rst/sig", a_sig, 64'd0);
    chk("rst/toggles", 64'(a_tog), 64'd0);
    chk("rst/overflow", 64'(a_ovf), 64'd0);
    dcount = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (a_done) dcount++;
    end
    chk("rst/no_done", 64'(dcount), 64'd0);
    sb.push_back('{0, 2'b00, 2'b01, 16'h0010, 2'b00, 1'b0, 64'h0});
    run_vec(0, 19, "rst_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
